sha256_stream_core: RTL and testbench

- Parametrised successor to the single-rate SHA-256 duct.
- Hashes a message of any number of pre-padded 512-bit blocks.
- Uses a valid/ready block handshake and a configurable rounds-per-cycle unroll.
- Holds a 256-bit digest output until it is consumed; sits between the block-feeding front end and the result consumer.

---
 rtl/sha256_pkg.sv | 58 +++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_stream_core.sv | 140 ++++++++++++++
 tb/tb_sha256_stream_core.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, initial hash values, FSM states and round helper functions
package sha256_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // word-wise 32-bit wrap-around sum of two packed H0..H7 vectors
   function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      return r;
   endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round on packed {a,b,c,d,e,f,g,h}
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] s_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] s_out
);

   logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

   // unpack working variables, compute T1/T2 and rotate the register file
   always_comb begin
      {a, b, c, d, e, f, g, h} = s_in;
      t1 = h + bsig1(e) + ch(e, f, g) + k + w;
      t2 = bsig0(a) + maj(a, b, c);
      s_out = {t1 + t2, a, b, c, d + t1, e, f, g};
   end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: multi-block SHA-256 engine, RPC rounds per cycle, valid/ready in and out; SHA256_SHA224_EN adds SHA-224 mode
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int RPC   = 1,
   parameter int DIG_W = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic             blk_last,
   input  logic [511:0]     block_data,
`ifdef SHA256_SHA224_EN
   input  logic             mode_224,
`endif
   output logic             digest_valid,
   input  logic             digest_ready,
   output logic [DIG_W-1:0] digest,
   output logic             busy
);

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : bad_rpc
      $error("sha256_stream_core: RPC must be 1, 2, 4 or 8");
   end
   if (DIG_W != 256) begin : bad_dig_w
      $error("sha256_stream_core: DIG_W must be 256");
   end

   state_t       state_q, state_d;
   logic [5:0]   t_q, t_d;
   logic [511:0] w_q, w_d, r_w;
   logic [255:0] s_q, s_d, h_q, h_d, dig_q, dig_d, r_s, sums, h_start;
   logic         last_q, last_d, dv_q, dv_d, busy_q, busy_d, first_q, first_d, m_q, m_d, mode_in;

`ifdef SHA256_SHA224_EN
   assign mode_in = mode_224;
`else
   assign mode_in = 1'b0;
`endif

   for (genvar i = 0; i < RPC; i++) begin : g
      logic [255:0] s_in, s_out;
      logic [511:0] w_in, w_out;
      if (i == 0) begin : f
         assign s_in = s_q;
         assign w_in = w_q;
      end else begin : n
         assign s_in = g[i-1].s_out;
         assign w_in = g[i-1].w_out;
      end
      assign w_out = {w_in[479:0], ssig1(w_in[63:32]) + w_in[223:192] + ssig0(w_in[479:448]) + w_in[511:480]};
      sha256_round u_rnd (.s_in(s_in), .k(K[t_q + 6'(i)]), .w(w_in[511:480]), .s_out(s_out));
   end

   assign r_s  = g[RPC-1].s_out;
   assign r_w  = g[RPC-1].w_out;
   assign sums = add8(h_q, s_q);

   // next-state logic: block intake, round stepping, chaining update and digest hand-off
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      w_d     = w_q;
      s_d     = s_q;
      h_d     = h_q;
      last_d  = last_q;
      dv_d    = dv_q;
      dig_d   = dig_q;
      first_d = first_q;
      m_d     = m_q;
      h_start = first_q ? (mode_in ? IV224 : IV256) : h_q;
      case (state_q)
         IDLE: if (blk_valid) begin
            state_d = ROUND;
            t_d     = '0;
            w_d     = block_data;
            last_d  = blk_last;
            s_d     = h_start;
            h_d     = h_start;
            first_d = 1'b0;
            m_d     = first_q ? mode_in : m_q;
         end
         ROUND: begin
            s_d     = r_s;
            w_d     = r_w;
            t_d     = t_q + 6'(RPC);
            state_d = (t_q == 6'(64 - RPC)) ? UPDATE : ROUND;
         end
         UPDATE: begin
            state_d = last_q ? DONE : IDLE;
            h_d     = last_q ? IV256 : sums;
            first_d = last_q;
            dv_d    = last_q;
            dig_d   = last_q ? (m_q ? {sums[255:32], 32'h0} : sums) : dig_q;
         end
         DONE: if (digest_ready) begin
            dv_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == ROUND) || (state_d == UPDATE);
   end

   // state registers; synchronous active-low reset discards any block in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         w_q     <= '0;
         s_q     <= '0;
         h_q     <= IV256;
         last_q  <= 1'b0;
         dv_q    <= 1'b0;
         dig_q   <= '0;
         busy_q  <= 1'b0;
         first_q <= 1'b1;
         m_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         w_q     <= w_d;
         s_q     <= s_d;
         h_q     <= h_d;
         last_q  <= last_d;
         dv_q    <= dv_d;
         dig_q   <= dig_d;
         busy_q  <= busy_d;
         first_q <= first_d;
         m_q     <= m_d;
      end
   end

   assign blk_ready    = (state_q == IDLE) && reset_n;
   assign digest_valid = dv_q;
   assign digest       = dig_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: randomized and known-answer bench for sha256_stream_core against a software SHA-256 model
module tb_sha256_stream_core;

   localparam int RPC = 4;
   localparam int LAT = 64 / RPC + 1;

   localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] M_IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] M_IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [31:0] KT [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk = 1'b0, reset_n = 1'b0, blk_valid = 1'b0, blk_last = 1'b0, digest_ready = 1'b0;
   logic [511:0] block_data = '0;
   logic         blk_ready, digest_valid, busy;
   logic [255:0] digest;
`ifdef SHA256_SHA224_EN
   logic         mode_224 = 1'b0;
`endif

   int checks = 0, errors = 0;
   logic [511:0] msg [$];
   logic [511:0] b_abc, b_empty, b_two1, b_two2;

   always #5 clk = ~clk;

   sha256_stream_core #(.RPC(RPC), .DIG_W(256)) dut (
      .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_last(blk_last), .block_data(block_data),
`ifdef SHA256_SHA224_EN
      .mode_224(mode_224),
`endif
      .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest), .busy(busy)
   );

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] hout;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return hout;
   endfunction

   function automatic logic [255:0] hash_msg(input bit m224);
      logic [255:0] h;
      h = m224 ? M_IV224 : M_IV256;
      foreach (msg[i]) h = compress(h, msg[i]);
      return m224 ? {h[255:32], 32'h0} : h;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
      return b;
   endfunction

   task automatic send_block(input logic [511:0] d, input logic l);
      int n;
      n = 0;
      block_data = d;
      blk_last   = l;
      blk_valid  = 1'b1;
      while (!blk_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (blk_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_block_timeout: blk_ready=%b after %0d cycles, required 1", blk_ready, n);
      end
      @(posedge clk); #1;
      blk_valid = 1'b0;
      blk_last  = 1'b0;
   endtask

   task automatic get_digest(input int hold, output logic [255:0] d, output int cyc);
      cyc = 0;
      while (!digest_valid && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (digest_valid !== 1'b1) begin
         errors++;
         $display("FAIL digest_timeout: digest_valid=%b after %0d cycles, required 1", digest_valid, cyc);
      end
      d = digest;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      blk_valid  = 1'b1;
      block_data = rand_block();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (blk_ready !== 1'b0) begin errors++; $display("FAIL reset_blk_ready: got %b, required 0", blk_ready); end
      checks++;
      if (digest_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_flags: digest_valid=%b busy=%b, required 0 0", digest_valid, busy);
      end
      checks++;
      if (digest !== 256'h0) begin errors++; $display("FAIL reset_digest: got %h, required 0", digest); end
      blk_valid = 1'b0;
      reset_n   = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (blk_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_ready: blk_ready=%b busy=%b, required 1 0", blk_ready, busy);
      end
   endtask

   task automatic test_abc();
      logic [255:0] d;
      int cyc;
      send_block(b_abc, 1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy: got %b, required 1", busy); end
      get_digest(0, d, cyc);
      checks++;
      if (d !== D_ABC) begin errors++; $display("FAIL abc_digest: got %h, required %h", d, D_ABC); end
      checks++;
      if (cyc != LAT) begin errors++; $display("FAIL abc_latency: got %0d cycles, required %0d", cyc, LAT); end
   endtask

   task automatic test_two_block();
      logic [255:0] d;
      int cyc, n;
      msg = '{b_two1, b_two2};
      send_block(b_two1, 1'b0);
      n = 0;
      while (!blk_ready && n < 400) begin
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != LAT) begin errors++; $display("FAIL two_ready_low: got %0d cycles, required %0d", n, LAT); end
      send_block(b_two2, 1'b1);
      get_digest(1, d, cyc);
      checks++;
      if (d !== D_TWO) begin errors++; $display("FAIL two_digest: got %h, required %h", d, D_TWO); end
      checks++;
      if (d !== hash_msg(1'b0)) begin errors++; $display("FAIL two_model: got %h, required %h", d, hash_msg(1'b0)); end
   endtask

   task automatic test_empty_then_abc();
      logic [255:0] d;
      int cyc;
      send_block(b_empty, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== D_EMPTY) begin errors++; $display("FAIL empty_digest: got %h, required %h", d, D_EMPTY); end
      send_block(b_abc, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== D_ABC) begin errors++; $display("FAIL iv_reload_abc: got %h, required %h", d, D_ABC); end
   endtask

   task automatic test_hold();
      int cyc;
      digest_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      digest_ready = 1'b0;
      checks++;
      if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
         errors++; $display("FAIL idle_digest_ready: digest_valid=%b blk_ready=%b, required 0 1", digest_valid, blk_ready);
      end
      send_block(b_abc, 1'b1);
      cyc = 0;
      while (!digest_valid && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      blk_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         block_data = rand_block();
         blk_last   = 1'(i & 1);
         @(posedge clk); #1;
         checks++;
         if (digest !== D_ABC || digest_valid !== 1'b1 || blk_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: digest=%h valid=%b ready=%b busy=%b, required %h 1 0 0",
                     i, digest, digest_valid, blk_ready, busy, D_ABC);
         end
      end
      blk_valid    = 1'b0;
      blk_last     = 1'b0;
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      checks++;
      if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
         errors++; $display("FAIL release_handshake: digest_valid=%b blk_ready=%b, required 0 1", digest_valid, blk_ready);
      end
   endtask

   task automatic test_mid_reset();
      logic [255:0] d;
      int cyc;
      send_block(b_two1, 1'b0);
      send_block(b_two2, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy); end
      reset_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (digest !== 256'h0 || digest_valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: digest=%h valid=%b busy=%b ready=%b, required 0 0 0 0",
                  digest, digest_valid, busy, blk_ready);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (blk_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_release: blk_ready=%b, required 1", blk_ready); end
      send_block(b_abc, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== D_ABC) begin errors++; $display("FAIL mid_reset_abc: got %h, required %h", d, D_ABC); end
   endtask

   task automatic test_random();
      logic [255:0] d, exp_d;
      int cyc, nb;
      for (int m = 0; m < 8; m++) begin
         nb = $urandom_range(1, 3);
         msg.delete();
         for (int b = 0; b < nb; b++) msg.push_back(rand_block());
         exp_d = hash_msg(1'b0);
         foreach (msg[b]) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_block(msg[b], 1'(b == nb - 1));
         end
         get_digest($urandom_range(0, 4), d, cyc);
         checks++;
         if (d !== exp_d) begin errors++; $display("FAIL random_msg%0d (%0d blocks): got %h, required %h", m, nb, d, exp_d); end
      end
   endtask

`ifdef SHA256_SHA224_EN
   task automatic test_sha224();
      logic [255:0] d, exp_d;
      int cyc;
      mode_224 = 1'b1;
      send_block(b_abc, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0}) begin
         errors++; $display("FAIL sha224_abc: got %h", d);
      end
      msg = '{b_two1, b_two2};
      exp_d = hash_msg(1'b1);
      send_block(b_two1, 1'b0);
      mode_224 = 1'b0;
      send_block(b_two2, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== exp_d) begin errors++; $display("FAIL sha224_first_sample: got %h, required %h", d, exp_d); end
      send_block(b_abc, 1'b1);
      get_digest(0, d, cyc);
      checks++;
      if (d !== D_ABC) begin errors++; $display("FAIL sha224_back_to_256: got %h, required %h", d, D_ABC); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      b_abc   = {32'h61626380, 416'h0, 64'h18};
      b_empty = {32'h80000000, 480'h0};
      b_two1  = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
                 64'h80000000_00000000};
      b_two2  = {448'h0, 64'h1c0};
      test_reset();
      test_abc();
      test_two_block();
      test_empty_then_abc();
      test_hold();
      test_mid_reset();
      test_random();
`ifdef SHA256_SHA224_EN
      test_sha224();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
